// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: byte FIFO with programmable almost-full/almost-empty
// thresholds, a sticky overflow/underflow error state, and an
// init/idle/active control FSM. All logic runs on the rising edge of CLK;
// RESET is synchronous and active-low.
module fifo_flow_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              init,
  input  logic [ADDR_W:0]   TH_AF,
  input  logic [ADDR_W:0]   TH_AE,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              WRITE,
  input  logic              read,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error,
  output logic [2:0]        state
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Count value of a completely full FIFO (2**ADDR_W in ADDR_W+1 bits).
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_RESET  = 3'b000,
    S_INIT   = 3'b001,
    S_IDLE   = 3'b010,
    S_ACTIVE = 3'b011,
    S_ERROR  = 3'b100
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     count_next;
  logic [ADDR_W:0]     th_af_r;
  logic [ADDR_W:0]     th_ae_r;

  logic run;
  logic underflow;
  logic overflow;
  logic push_ok;
  logic pop_ok;

  // Status flags follow the registered count and the latched thresholds.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= th_af_r);
  assign almost_empty = (count <= th_ae_r);
  assign state        = state_q;

  // Decode which transfers happen this cycle; init pre-empts all traffic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    run        = 1'b0;
    underflow  = 1'b0;
    overflow   = 1'b0;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    if ((state_q == S_IDLE || state_q == S_ACTIVE) && !init) begin
      run = 1'b1;
    end
    if (run) begin
      // A read on an empty FIFO blocks a simultaneous write as well.
      underflow = read && empty;
      overflow  = WRITE && full && !read;
      pop_ok    = read && !empty;
      push_ok   = WRITE && (!full || read) && !underflow;
    end
    count_next = count + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop_ok);
  end

  // Storage array: written on accepted pushes only.
  // NOTE: the data array has no reset; validity is tracked by count and pointers.
  always_ff @(posedge CLK) begin
    if (RESET && push_ok) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  // Control FSM with pointers, count, thresholds and registered outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RESET) begin
      state_q   <= S_RESET;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      DATA_OUT  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
      th_af_r   <= DEPTH_C;
      th_ae_r   <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state_q)
        S_RESET: begin
          state_q <= S_INIT;
        end

        S_INIT: begin
          th_af_r <= TH_AF;
          th_ae_r <= TH_AE;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          count   <= '0;
          error   <= 1'b0;
          if (!init) begin
            state_q <= S_IDLE;
          end
        end

        S_IDLE, S_ACTIVE: begin
          if (init) begin
            state_q <= S_INIT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error   <= 1'b0;
          end else if (overflow || underflow) begin
            state_q <= S_ERROR;
            error   <= 1'b1;
          end else begin
            if (push_ok) begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
              rd_ptr    <= rd_ptr + ADDR_W'(1);
              DATA_OUT  <= mem[rd_ptr];
              valid_out <= 1'b1;
            end
            count   <= count_next;
            state_q <= (count_next == '0) ? S_IDLE : S_ACTIVE;
          end
        end

        S_ERROR: begin
          // Frozen until re-initialised; flags keep their last value.
          if (init) begin
            state_q <= S_INIT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            error   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed testbench for fifo_flow_ctrl: reset/init, fill/drain ordering,
// full pass-through, overflow and underflow error handling, mid-stream reset
// and pointer wrap-around.
module tb_fifo_flow_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              init;
  logic [ADDR_W:0]   TH_AF;
  logic [ADDR_W:0]   TH_AE;
  logic [DATA_W-1:0] DATA_IN;
  logic              WRITE;
  logic              read;
  logic [DATA_W-1:0] DATA_OUT;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              error;
  logic [2:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  fifo_flow_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .init         (init),
    .TH_AF        (TH_AF),
    .TH_AE        (TH_AE),
    .DATA_IN      (DATA_IN),
    .WRITE        (WRITE),
    .read         (read),
    .DATA_OUT     (DATA_OUT),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error),
    .state        (state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    DATA_IN = d; WRITE = 1'b1; read = 1'b0;
    step();
    WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; init = 1'b0; TH_AF = 4'd6; TH_AE = 4'd1;
    DATA_IN = '0; WRITE = 1'b0; read = 1'b0;

    // 1. Reset then init
    step(); step();
    check("rst_state", 32'(state), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_aempty", 32'(almost_empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_afull", 32'(almost_full), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_dout", 32'(DATA_OUT), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    RESET = 1'b1; init = 1'b1;
    step();
    check("init_state", 32'(state), 32'h1);
    step();
    init = 1'b0;
    step();
    check("idle_state", 32'(state), 32'h2);
    check("idle_empty", 32'(empty), 32'h1);
    check("idle_aempty", 32'(almost_empty), 32'h1);
    check("idle_error", 32'(error), 32'h0);

    // 2. Fill with 8 bytes, then drain in order
    for (int i = 0; i < 8; i++) begin
      push(8'h0F + 8'(i));
      check($sformatf("fill%0d_afull", i), 32'(almost_full), 32'(i + 1 >= 6));
      check($sformatf("fill%0d_full", i), 32'(full), 32'(i == 7));
      check($sformatf("fill%0d_aempty", i), 32'(almost_empty), 32'(i + 1 <= 1));
      check($sformatf("fill%0d_state", i), 32'(state), 32'h3);
    end
    for (int i = 0; i < 8; i++) begin
      read = 1'b1;
      step();
      check($sformatf("drain%0d_dout", i), 32'(DATA_OUT), 32'h0F + 32'(i));
      check($sformatf("drain%0d_valid", i), 32'(valid_out), 32'h1);
    end
    read = 1'b0;
    check("drain_state", 32'(state), 32'h2);
    check("drain_empty", 32'(empty), 32'h1);
    step();
    check("hold_valid", 32'(valid_out), 32'h0);
    check("hold_dout", 32'(DATA_OUT), 32'h16);

    // 3. Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    check("pre3_full", 32'(full), 32'h1);
    for (int i = 0; i < 3; i++) begin
      DATA_IN = 8'h30 + 8'(i); WRITE = 1'b1; read = 1'b1;
      step();
      check($sformatf("pass%0d_dout", i), 32'(DATA_OUT), 32'h20 + 32'(i));
      check($sformatf("pass%0d_full", i), 32'(full), 32'h1);
      check($sformatf("pass%0d_error", i), 32'(error), 32'h0);
    end

    // 4. Overflow, frozen error state, recovery via init
    DATA_IN = 8'h40; WRITE = 1'b1; read = 1'b0;
    step();
    check("ovf_error", 32'(error), 32'h1);
    check("ovf_state", 32'(state), 32'h4);
    check("ovf_full", 32'(full), 32'h1);
    WRITE = 1'b0; read = 1'b1;
    step();
    check("err_valid", 32'(valid_out), 32'h0);
    check("err_dout", 32'(DATA_OUT), 32'h22);
    check("err_full", 32'(full), 32'h1);
    check("err_state", 32'(state), 32'h4);
    read = 1'b0; init = 1'b1;
    step();
    check("reinit_state", 32'(state), 32'h1);
    check("reinit_error", 32'(error), 32'h0);
    check("reinit_empty", 32'(empty), 32'h1);
    init = 1'b0;
    step();
    check("reinit_idle", 32'(state), 32'h2);

    // 5. Underflow with a simultaneous write
    DATA_IN = 8'h55; WRITE = 1'b1; read = 1'b1;
    step();
    WRITE = 1'b0; read = 1'b0;
    check("udf_error", 32'(error), 32'h1);
    check("udf_empty", 32'(empty), 32'h1);
    check("udf_state", 32'(state), 32'h4);
    check("udf_valid", 32'(valid_out), 32'h0);
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    check("udf_recover", 32'(state), 32'h2);

    // 6. Mid-stream reset, re-init, pointer wrap
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    RESET = 1'b0; WRITE = 1'b1; DATA_IN = 8'hEE;
    step();
    WRITE = 1'b0;
    check("mrst_state", 32'(state), 32'h0);
    check("mrst_empty", 32'(empty), 32'h1);
    check("mrst_dout", 32'(DATA_OUT), 32'h0);
    check("mrst_afull", 32'(almost_full), 32'h0);
    RESET = 1'b1; init = 1'b1;
    step();
    init = 1'b0;
    step();
    check("wrap_idle", 32'(state), 32'h2);
    push(8'h50);
    for (int i = 0; i < 20; i++) begin
      DATA_IN = 8'h51 + 8'(i); WRITE = 1'b1; read = 1'b1;
      step();
      check($sformatf("wrap%0d_dout", i), 32'(DATA_OUT), 32'h50 + 32'(i));
      check($sformatf("wrap%0d_valid", i), 32'(valid_out), 32'h1);
    end
    WRITE = 1'b0; read = 1'b1;
    step();
    read = 1'b0;
    check("wrap_last", 32'(DATA_OUT), 32'h64);
    check("wrap_empty", 32'(empty), 32'h1);
    check("wrap_state", 32'(state), 32'h2);
    check("wrap_error", 32'(error), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
